// File: rtl/d_lsu_pkg.sv
// Shared types for the load/store control stage: op sizes, fault causes and FSM states.
package d_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_RSVD     = 2'b11
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_CAPT = 2'b10
    } state_e;

endpackage

// File: rtl/d_lsu_align_chk.sv
// Combinational alignment and size legality check for an incoming memory op.
module d_lsu_align_chk
    import d_lsu_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] size,
    output logic       misaligned,
    output logic       reserved
);

    always_comb begin
        misaligned = 1'b0;
        reserved   = 1'b0;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = |addr_lo;
            SZ_RSVD: reserved   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/d_lsu_ctrl.sv
// Load/store control stage: validates ops from execute, drives the d-cache request
// and returns load data / store completion / faults as single-cycle pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new op; illegal ops fault without leaving IDLE
// ST_REQ  | cache request held stable until busy drops or watchdog fires
// ST_CAPT | load data registered from cache, wb pulse follows in IDLE
module d_lsu_ctrl
    import d_lsu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic              ex_wr_i,
    input  logic [1:0]        ex_byte_en_i,
    input  logic              ex_zero_extnd_i,
    input  logic [DATA_W-1:0] ex_wr_data_i,
    input  logic [4:0]        ex_rd_i,
    output logic              data_req_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [1:0]        data_byte_en_o,
    output logic              data_wr_o,
    output logic [DATA_W-1:0] data_wr_data_o,
    output logic              data_zero_extnd_o,
    input  logic              d_cache_busy_i,
    input  logic [DATA_W-1:0] data_rd_data_i,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [4:0]        wb_rd_o,
    output logic              st_done_o,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o,
    output logic              stall_o
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_e       state_q, state_d;
    logic [CNT_W-1:0] busy_cnt_q;
    logic [4:0]   rd_q;
    logic         misaligned, reserved;
    logic         accept, timeout;
    logic         st_done_d, fault_d, wb_valid_d;
    fault_cause_e cause_d;

    d_lsu_align_chk u_align_chk (
        .addr_lo    (ex_addr_i[1:0]),
        .size       (ex_byte_en_i),
        .misaligned (misaligned),
        .reserved   (reserved)
    );

    assign timeout = (state_q == ST_REQ) && d_cache_busy_i
                     && (busy_cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ex_valid_i && !reserved && !misaligned) state_d = ST_REQ;
            ST_REQ: begin
                if (d_cache_busy_i) begin
                    if (timeout) state_d = ST_IDLE;
                end else if (data_wr_o) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_ready_o = (state_q == ST_IDLE);
        stall_o    = (state_q != ST_IDLE);
        accept     = ex_ready_o && ex_valid_i && !reserved && !misaligned;
        st_done_d  = (state_q == ST_REQ) && !d_cache_busy_i && data_wr_o;
        wb_valid_d = (state_q == ST_CAPT);
        fault_d    = (ex_ready_o && ex_valid_i && (reserved || misaligned)) || timeout;
        cause_d    = FAULT_NONE;
        if (timeout)       cause_d = FAULT_TIMEOUT;
        else if (!fault_d) cause_d = FAULT_NONE;
        else if (reserved) cause_d = FAULT_RSVD;
        else               cause_d = FAULT_MISALIGN;
    end

    // Registered outputs; the data_* fields stay put for the whole REQ phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_req_o        <= 1'b0;
            data_addr_o       <= '0;
            data_byte_en_o    <= '0;
            data_wr_o         <= 1'b0;
            data_wr_data_o    <= '0;
            data_zero_extnd_o <= 1'b0;
            rd_q              <= '0;
            busy_cnt_q        <= '0;
            wb_valid_o        <= 1'b0;
            wb_data_o         <= '0;
            wb_rd_o           <= '0;
            st_done_o         <= 1'b0;
            fault_o           <= 1'b0;
            fault_cause_o     <= FAULT_NONE;
        end else begin
            data_req_o    <= (state_d == ST_REQ);
            wb_valid_o    <= wb_valid_d;
            st_done_o     <= st_done_d;
            fault_o       <= fault_d;
            fault_cause_o <= cause_d;
            if (accept) begin
                data_addr_o       <= ex_addr_i;
                data_byte_en_o    <= ex_byte_en_i;
                data_wr_o         <= ex_wr_i;
                data_wr_data_o    <= ex_wr_data_i;
                data_zero_extnd_o <= ex_zero_extnd_i;
                rd_q              <= ex_rd_i;
                busy_cnt_q        <= '0;
            end else if ((state_q == ST_REQ) && d_cache_busy_i) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
            end
            if (state_q == ST_CAPT) begin
                wb_data_o <= data_rd_data_i;
                wb_rd_o   <= rd_q;
            end
        end
    end

endmodule
